// File: rtl/ro_puf_engine.sv
// rtl/ro_puf_engine.sv - serialized ring-oscillator PUF race controller
// Expands a challenge through an LFSR into oscillator pairs and races them edge-count-to-threshold.
module ro_puf_engine #(
  parameter int NUM_RO = 8,
  parameter int CHAL_W = 8,
  parameter int RESP_W = 8,
  parameter int CNT_W = 10,
  parameter int THRESH = 1000,
  parameter int TIMEOUT = 65535,
  parameter logic [CHAL_W-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] chall_in,
  input  logic [NUM_RO-1:0] ro_g1,
  input  logic [NUM_RO-1:0] ro_g2,
  output logic              ro_en,
  output logic              busy,
  output logic              valid,
  input  logic              ack,
  output logic [RESP_W-1:0] response,
  output logic              err_timeout,
  output logic [3:0]        tie_count
);
  localparam int SEL_W = $clog2(NUM_RO);
  localparam int IDX_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RACE  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESH - 1);
  localparam logic [15:0]      TO_M1  = 16'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(RESP_W - 1);

  logic [1:0]        state;
  logic [1:0]        flush_cnt;
  logic [CHAL_W-1:0] lfsr;
  logic [CHAL_W-1:0] lfsr_next;
  logic [SEL_W-1:0]  sel1, sel2;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  cnt1, cnt2;
  logic [15:0]       cyc;
  logic [1:0]        sync1, sync2;
  logic              prev1, prev2;
  logic              rise1, rise2, hit1, hit2, to_hit, flush_last;

  assign lfsr_next  = {lfsr[CHAL_W-2:0], ^(lfsr & LFSR_TAPS)};
  assign rise1      = sync1[1] & ~prev1;
  assign rise2      = sync2[1] & ~prev2;
  assign hit1       = rise1 && (cnt1 == THR_M1);
  assign hit2       = rise2 && (cnt2 == THR_M1);
  assign to_hit     = (cyc == TO_M1);
  assign flush_last = (state == S_FLUSH) && (flush_cnt == 2'd2);

  assign ro_en = (state == S_FLUSH) || (state == S_RACE);
  assign busy  = ro_en;
  assign valid = (state == S_DONE);

  // On the last flush cycle the edge flop is preloaded with the value the 2nd flop
  // is about to take, so a level left over from the previous pair is never seen as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev1 <= 1'b0;
      prev2 <= 1'b0;
    end else begin
      sync1 <= {sync1[0], ro_g1[sel1]};
      sync2 <= {sync2[0], ro_g2[sel2]};
      prev1 <= flush_last ? sync1[0] : sync1[1];
      prev2 <= flush_last ? sync2[0] : sync2[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      flush_cnt   <= '0;
      lfsr        <= '0;
      sel1        <= '0;
      sel2        <= '0;
      bit_idx     <= '0;
      cnt1        <= '0;
      cnt2        <= '0;
      cyc         <= '0;
      response    <= '0;
      err_timeout <= 1'b0;
      tie_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lfsr        <= (chall_in == '0) ? '1 : chall_in;
            bit_idx     <= '0;
            response    <= '0;
            err_timeout <= 1'b0;
            tie_count   <= '0;
            flush_cnt   <= '0;
            state       <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          cnt1      <= '0;
          cnt2      <= '0;
          cyc       <= '0;
          flush_cnt <= flush_cnt + 2'd1;
          if (flush_cnt == 2'd0) begin
            lfsr <= lfsr_next;
            sel1 <= lfsr_next[SEL_W-1:0];
            sel2 <= lfsr_next[CHAL_W-1 -: SEL_W];
          end
          if (flush_last) state <= S_RACE;
        end
        S_RACE: begin
          if (rise1 && cnt1 != THR) cnt1 <= cnt1 + 1'b1;
          if (rise2 && cnt2 != THR) cnt2 <= cnt2 + 1'b1;
          cyc <= cyc + 16'd1;
          if (hit1 || hit2) begin
            response[bit_idx] <= hit1 && !hit2;
            if (hit1 && hit2 && tie_count != 4'hF) tie_count <= tie_count + 4'd1;
            if (bit_idx == LAST) begin
              state <= S_DONE;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              flush_cnt <= '0;
              state     <= S_FLUSH;
            end
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            response    <= '0;
            state       <= S_DONE;
          end
        end
        default: begin
          if (ack) state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ro_puf_engine.sv
// tb/tb_ro_puf_engine.sv - randomized self-checking bench for ro_puf_engine
// Oscillators share one time base, so equal periods give identical waveforms (exact ties).
module tb_ro_puf_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] chall_in = 8'h00;
  logic [7:0] ro_g1 = 8'h00;
  logic [7:0] ro_g2 = 8'h00;
  logic       ack = 1'b0;
  logic       ro_en, busy, valid, err_timeout;
  logic [7:0] response;
  logic [3:0] tie_count;

  int checks = 0;
  int errors = 0;
  int per1 [8];
  int per2 [8];
  int tcount = 0;
  logic [7:0] exp_resp;
  logic       exp_err;
  logic [3:0] exp_tie;
  bit         model_ok = 1'b0;

  ro_puf_engine #(
    .NUM_RO(8), .CHAL_W(8), .RESP_W(8), .CNT_W(10),
    .THRESH(4), .TIMEOUT(200), .LFSR_TAPS(8'hB8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .chall_in(chall_in),
    .ro_g1(ro_g1), .ro_g2(ro_g2), .ro_en(ro_en), .busy(busy),
    .valid(valid), .ack(ack), .response(response),
    .err_timeout(err_timeout), .tie_count(tie_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcount = tcount + 1;
    for (int i = 0; i < 8; i++) begin
      ro_g1[i] = (per1[i] == 0) ? 1'b0 : ((tcount % per1[i]) < per1[i] / 2);
      ro_g2[i] = (per2[i] == 0) ? 1'b0 : ((tcount % per2[i]) < per2[i] / 2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic [7:0] t;
    t = l & 8'hB8;
    return {l[6:0], 1'($countones(t) % 2)};
  endfunction

  // Faster oscillator wins; equal period ties; two dead oscillators time out the challenge.
  task automatic model(input logic [7:0] chal);
    logic [7:0] l;
    int s1, s2, p1, p2;
    l = (chal == 8'h00) ? 8'hFF : chal;
    exp_resp = 8'h00;
    exp_err  = 1'b0;
    exp_tie  = 4'd0;
    for (int r = 0; r < 8; r++) begin
      l  = lfsr_step(l);
      s1 = int'(l) % 8;
      s2 = int'(l) / 32;
      p1 = per1[s1];
      p2 = per2[s2];
      if (p1 == 0 && p2 == 0) begin
        exp_err  = 1'b1;
        exp_resp = 8'h00;
        break;
      end
      if (p1 == p2) begin
        if (exp_tie != 4'hF) exp_tie = exp_tie + 4'd1;
      end else if (p2 == 0 || (p1 != 0 && p1 < p2)) begin
        exp_resp[r] = 1'b1;
      end
    end
    model_ok = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && model_ok) begin
      if (valid) begin
        chk("response", 32'(response), 32'(exp_resp));
        chk("err_timeout", 32'(err_timeout), 32'(exp_err));
        chk("tie_count", 32'(tie_count), 32'(exp_tie));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("ro_en_in_done", 32'(ro_en), 32'd0);
      end else if (busy) begin
        chk("ro_en_while_busy", 32'(ro_en), 32'd1);
      end
    end
  end

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < 8; i++) begin
      per1[i] = a;
      per2[i] = b;
    end
  endtask

  task automatic rand_pers();
    int opts [5];
    opts = '{0, 6, 10, 14, 30};
    for (int i = 0; i < 8; i++) begin
      per1[i] = opts[($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4)];
      per2[i] = opts[($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4)];
    end
  endtask

  task automatic run_chal(input logic [7:0] chal, input int hold, input bit poke, output int lat);
    int n;
    n = 0;
    while ((busy || valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start = 1'b1;
    chall_in = chal;
    model(chal);
    @(negedge clk);
    start = 1'b0;
    chall_in = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!valid && n < 4000) begin
      @(negedge clk);
      n++;
      start = (poke && n == 10);
      if (start) chall_in = ~chal;
    end
    start = 1'b0;
    lat = n;
    chk("valid_within_budget", 32'(valid), 32'd1);
    repeat (hold) @(negedge clk);
    chk("valid_held_before_ack", 32'(valid), 32'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("valid_drop_after_ack", 32'(valid), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    set_all(0, 0);
    #2;
    chk("rst_response", 32'(response), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_tie", 32'(tie_count), 32'd0);
    chk("model_step_ff", 32'(lfsr_step(8'hFF)), 32'hFE);
    chk("model_step_a5", 32'(lfsr_step(8'hA5)), 32'h4A);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    set_all(10, 14);
    run_chal(8'hA5, 3, 1'b0, lat);
    chk("t1_model_resp", 32'(exp_resp), 32'hFF);
    chk("t1_model_tie", 32'(exp_tie), 32'd0);

    set_all(14, 10);
    run_chal(8'h3C, 20, 1'b0, lat);
    chk("t2_model_resp", 32'(exp_resp), 32'h00);

    set_all(14, 10);
    per1[6] = 6;
    run_chal(8'h00, 2, 1'b0, lat);
    chk("t3_model_bit0", 32'(exp_resp[0]), 32'd1);

    set_all(10, 10);
    run_chal(8'h5A, 2, 1'b0, lat);
    chk("t4_model_tie", 32'(exp_tie), 32'd8);
    chk("t4_model_resp", 32'(exp_resp), 32'h00);

    set_all(0, 0);
    run_chal(8'h77, 2, 1'b1, lat);
    chk("t5_model_err", 32'(exp_err), 32'd1);
    chk("t5_latency_window", 32'(lat >= 202 && lat <= 206), 32'd1);

    set_all(30, 14);
    @(negedge clk);
    start = 1'b1;
    chall_in = 8'h91;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_response", 32'(response), 32'd0);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ro_en", 32'(ro_en), 32'd0);
    chk("t6_rst_err", 32'(err_timeout), 32'd0);
    chk("t6_rst_tie", 32'(tie_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_chal(8'h91, 1, 1'b0, lat);

    for (int k = 0; k < 12; k++) begin
      rand_pers();
      run_chal(8'($urandom), $urandom_range(0, 5), 1'($urandom_range(0, 1)), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
